bcd_hex_display: RTL

Parametrised, sequential binary-to-decimal display driver: converts an unsigned WIDTH-bit value into DIGITS BCD digits by iterative shift-and-add-3 (double dabble), then drives one active-low seven-segment pattern per digit. Generalises the fixed 4-bit, two-digit combinational decoder to arbitrary width with optional leading-zero blanking and a start/done handshake. It sits between datapath results (counters, ALU outputs) and the board HEX displays.

---
 rtl/bcd_hex_display_if.sv | 21 ++
 rtl/bcd_hex_display.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/bcd_hex_display_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_hex_display_if
// Brief    : Start/done handshake and result bus of the BCD/HEX display driver.
// Revision : 1.0  initial release
// ============================================================================
interface bcd_hex_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  Start;
    logic [WIDTH-1:0]      Bin;
    logic                  Busy;
    logic                  Done;
    logic [4*DIGITS-1:0]   BCD;
    logic [7*DIGITS-1:0]   HEX;

    modport master (output Start, output Bin, input Busy, input Done, input BCD, input HEX);
    modport slave  (input Start, input Bin, output Busy, output Done, output BCD, output HEX);
endinterface
`default_nettype wire

// File: rtl/bcd_hex_display.sv
`default_nettype none
// ============================================================================
// Module   : bcd_hex_display
// Brief    : Sequential double-dabble binary-to-BCD converter driving active-low
//            seven-segment patterns, with optional leading-zero blanking.
// Revision : 1.0  initial release
// ============================================================================
module bcd_hex_display #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int BLANK  = 1
) (
    input  wire logic          Clock,
    input  wire logic          Resetn,
    bcd_hex_display_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [6:0] C_SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] C_SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = C_SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [7*DIGITS-1:0] reset_hex();
        logic [7*DIGITS-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[7*i +: 7] = ((i == 0) || (BLANK == 0)) ? C_SEG_ZERO : C_SEG_BLANK;
        end
        return r;
    endfunction

    localparam logic [7*DIGITS-1:0] C_HEX_RESET = reset_hex();

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      shift_q, shift_d;
    logic [4*DIGITS-1:0]   acc_q,   acc_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [4*DIGITS-1:0]   bcd_q,   bcd_d;
    logic [7*DIGITS-1:0]   hex_q,   hex_d;
    logic                  done_q,  done_d;

    logic [4*DIGITS-1:0]   w_acc_adj;
    logic [7*DIGITS-1:0]   w_hex_next;

    // Add-3 correction applied to every digit before each shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        logic [3:0] w_dig;
        assign w_dig = acc_q[4*g +: 4];
        assign w_acc_adj[4*g +: 4] = (w_dig >= 4'd5) ? (w_dig + 4'd3) : w_dig;
    end

    // Scan from the top digit down; blanking stops at the first non-zero digit
    // and never reaches digit 0.
    always_comb begin
        logic       blank_run;
        logic [3:0] d;
        blank_run  = (BLANK != 0);
        w_hex_next = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d          = acc_q[4*i +: 4];
            blank_run  = blank_run && (d == 4'd0) && (i != 0);
            w_hex_next[7*i +: 7] = blank_run ? C_SEG_BLANK : seg7(d);
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        hex_d   = hex_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    shift_d = bus.Bin;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {acc_d, shift_d} = {w_acc_adj, shift_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bcd_d   = acc_q;
                hex_d   = w_hex_next;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            hex_q   <= C_HEX_RESET;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            hex_q   <= hex_d;
            done_q  <= done_d;
        end
    end

    assign bus.Busy = (state_q == S_SHIFT);
    assign bus.Done = done_q;
    assign bus.BCD  = bcd_q;
    assign bus.HEX  = hex_q;

endmodule
`default_nettype wire
